// File: rtl/regfile_sb_if.sv
// Register file bus: read ports, ALU/load write ports, issue, sweep-clear and debug tap.
// The master side is the pipeline and the slave side is regfile_sb.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr0_en;
  logic [ADDR_W-1:0]     wr0_addr;
  logic [DATA_W-1:0]     wr0_data;
  logic                  wr1_en;
  logic [ADDR_W-1:0]     wr1_addr;
  logic [DATA_W-1:0]     wr1_data;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  clr_req;
  logic                  clr_busy;
  logic                  clr_done;
  logic [DATA_W-1:0]     dbg_data;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           iss_en, iss_addr, clr_req,
    input  rd_data, rd_busy, clr_busy, clr_done, dbg_data
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           iss_en, iss_addr, clr_req,
    output rd_data, rd_busy, clr_busy, clr_done, dbg_data
  );
endinterface

// File: rtl/regfile_sb.sv
// General-purpose register file with busy scoreboard, sweep-clear engine and debug tap.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NRD     = 2,
  parameter int DBG_IDX = 9
) (
  input  logic       clk,
  input  logic       resetn,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DBG_A = ADDR_W'(DBG_IDX);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic              done_q;

  logic wr0_ok, wr1_ok, iss_ok;
  assign wr0_ok = bus.wr0_en && (bus.wr0_addr != '0);
  assign wr1_ok = bus.wr1_en && (bus.wr1_addr != '0);
  assign iss_ok = bus.iss_en && (bus.iss_addr != '0);

  // wr0 is applied after wr1 and issue after the write clears, so the later assignment wins.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy   <= '0;
      state  <= IDLE;
      ptr    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (wr1_ok) begin
            regs[bus.wr1_addr] <= bus.wr1_data;
            busy[bus.wr1_addr] <= 1'b0;
          end
          if (wr0_ok) begin
            regs[bus.wr0_addr] <= bus.wr0_data;
            busy[bus.wr0_addr] <= 1'b0;
          end
          if (iss_ok) busy[bus.iss_addr] <= 1'b1;
          if (bus.clr_req) begin
            state <= SWEEP;
            ptr   <= ADDR_W'(1);
          end
        end
        SWEEP: begin
          regs[ptr] <= '0;
          busy[ptr] <= 1'b0;
          ptr       <= ptr + 1'b1;
          if (ptr == LAST) begin
            state  <= IDLE;
            ptr    <= '0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic [ADDR_W-1:0]     a;
  logic [DATA_W-1:0]     d;
  logic                  b;

  // Read ports: r0 and reset force zero; optional forwarding only while writes are accepted.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    a     = '0;
    d     = '0;
    b     = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      a = bus.rd_addr[i*ADDR_W +: ADDR_W];
      d = regs[a];
      b = busy[a];
`ifdef REGFILE_SB_BYPASS_EN
      if (state == IDLE) begin
        if (wr0_ok && bus.wr0_addr == a) begin
          d = bus.wr0_data;
          b = iss_ok && (bus.iss_addr == a);
        end else if (wr1_ok && bus.wr1_addr == a) begin
          d = bus.wr1_data;
          b = iss_ok && (bus.iss_addr == a);
        end
      end
`else
`endif
      if (!resetn || a == '0) begin
        d = '0;
        b = 1'b0;
      end
      rdata[i*DATA_W +: DATA_W] = d;
      rbusy[i] = b;
    end
  end

  assign bus.rd_data  = rdata;
  assign bus.rd_busy  = rbusy;
  assign bus.clr_busy = resetn && (state == SWEEP);
  assign bus.clr_done = done_q;
  assign bus.dbg_data = resetn ? regs[DBG_A] : '0;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb: reset, writes, priority, scoreboard, sweep and reset abort.
// Expected values are hand-computed; forwarding checks follow REGFILE_SB_BYPASS_EN.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .DBG_IDX(9)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                               input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                               input logic ise, input logic [4:0] isa, input logic clr);
    bus.wr0_en = w0e; bus.wr0_addr = w0a; bus.wr0_data = w0d;
    bus.wr1_en = w1e; bus.wr1_addr = w1a; bus.wr1_data = w1d;
    bus.iss_en = ise; bus.iss_addr = isa; bus.clr_req = clr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readPair(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
    #1;
  endtask

  // Every register must read zero and not busy on both ports.
  task automatic checkAllZero(input string tag);
    for (int i = 0; i < 16; i++) begin
      readPair(5'(2*i), 5'(2*i+1));
      checkOutput($sformatf("%s_d%0d", tag, 2*i), bus.rd_data[31:0], 32'h0);
      checkOutput($sformatf("%s_d%0d", tag, 2*i+1), bus.rd_data[63:32], 32'h0);
      checkOutput($sformatf("%s_b%0d", tag, 2*i), {30'h0, bus.rd_busy}, 32'h0);
    end
  endtask

  logic [31:0] exp_same;
  logic [31:0] exp_busy;

  initial begin
    idle();
    bus.rd_addr = '0;
    tick();
    tick();
    readPair(5'd5, 5'd9);
    checkOutput("rst_rd", bus.rd_data[31:0], 32'h0);
    resetn = 1'b1;
    #1;

    // Test 1: reset state
    checkAllZero("reset");
    checkOutput("reset_dbg", bus.dbg_data, 32'h0);
    checkOutput("reset_clr_busy", {31'h0, bus.clr_busy}, 32'h0);
    checkOutput("reset_clr_done", {31'h0, bus.clr_done}, 32'h0);

    // Test 2: basic write and r0 hardwiring
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    idle();
    readPair(5'd5, 5'd5);
    checkOutput("wr_r5_p0", bus.rd_data[31:0], 32'hDEADBEEF);
    checkOutput("wr_r5_p1", bus.rd_data[63:32], 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd0, 32'h1, 1'b1, 5'd6, 32'hCAFE0006, 1'b0, 5'd0, 1'b0);
    tick();
    idle();
    readPair(5'd0, 5'd6);
    checkOutput("wr_r0", bus.rd_data[31:0], 32'h0);
    checkOutput("wr1_r6", bus.rd_data[63:32], 32'hCAFE0006);

    // Test 3: write port priority
    applyStimulus(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 1'b0);
    readPair(5'd7, 5'd5);
`ifdef REGFILE_SB_BYPASS_EN
    exp_same = 32'h11;
`else
    exp_same = 32'h0;
`endif
    checkOutput("prio_same_cycle", bus.rd_data[31:0], exp_same);
    tick();
    idle();
    readPair(5'd7, 5'd7);
    checkOutput("prio_r7", bus.rd_data[31:0], 32'h11);

    // Test 4: scoreboard
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
    tick();
    idle();
    readPair(5'd3, 5'd3);
    checkOutput("iss_busy", {30'h0, bus.rd_busy}, 32'h3);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h5, 1'b0, 5'd0, 1'b0);
    readPair(5'd3, 5'd4);
`ifdef REGFILE_SB_BYPASS_EN
    exp_busy = 32'h0;
`else
    exp_busy = 32'h1;
`endif
    checkOutput("wr1_busy_same", {30'h0, bus.rd_busy}, exp_busy);
    tick();
    idle();
    readPair(5'd3, 5'd3);
    checkOutput("wr1_busy_clr", {30'h0, bus.rd_busy}, 32'h0);
    checkOutput("wr1_r3", bus.rd_data[31:0], 32'h5);
    applyStimulus(1'b1, 5'd3, 32'h6, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
    readPair(5'd3, 5'd0);
`ifdef REGFILE_SB_BYPASS_EN
    exp_same = 32'h6; exp_busy = 32'h1;
`else
    exp_same = 32'h5; exp_busy = 32'h0;
`endif
    checkOutput("iss_wr_same_d", bus.rd_data[31:0], exp_same);
    checkOutput("iss_wr_same_b", {30'h0, bus.rd_busy}, exp_busy);
    tick();
    idle();
    readPair(5'd3, 5'd0);
    checkOutput("iss_wr_busy", {30'h0, bus.rd_busy}, 32'h1);
    checkOutput("iss_wr_r3", bus.rd_data[31:0], 32'h6);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
    tick();
    idle();
    readPair(5'd0, 5'd0);
    checkOutput("iss_r0", {30'h0, bus.rd_busy}, 32'h0);

    // Test 5: fill, then full sweep
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h100 + i, 1'b0, 5'd0, 32'h0, i == 31, 5'd10, 1'b0);
      tick();
    end
    idle();
    readPair(5'd10, 5'd31);
    checkOutput("fill_busy10", {30'h0, bus.rd_busy}, 32'h1);
    checkOutput("fill_r31", bus.rd_data[63:32], 32'h11F);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
    tick();
    cyc = 0;
    while (bus.clr_busy && cyc < 100) begin
      if (cyc == 10)
        applyStimulus(1'b1, 5'd4, 32'hABCD, 1'b1, 5'd2, 32'hEEEE, 1'b1, 5'd5, 1'b1);
      else
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, cyc < 10);
      if (cyc == 3) begin
        readPair(5'd3, 5'd20);
        checkOutput("sweep_r3", bus.rd_data[31:0], 32'h0);
        checkOutput("sweep_r20", bus.rd_data[63:32], 32'h114);
        checkOutput("sweep_done_early", {31'h0, bus.clr_done}, 32'h0);
      end
      tick();
      cyc++;
    end
    idle();
    checkOutput("sweep_len", cyc, 32'd31);
    checkOutput("sweep_done", {31'h0, bus.clr_done}, 32'h1);
    tick();
    checkOutput("sweep_done_pulse", {31'h0, bus.clr_done}, 32'h0);
    checkOutput("sweep_idle", {31'h0, bus.clr_busy}, 32'h0);
    checkAllZero("swept");

    // Test 6: reset aborts a sweep
    applyStimulus(1'b1, 5'd20, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    idle();
    checkOutput("dbg_77", bus.dbg_data, 32'h77);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 10; i++) tick();
    checkOutput("abort_busy_pre", {31'h0, bus.clr_busy}, 32'h1);
    resetn = 1'b0;
    readPair(5'd20, 5'd20);
    checkOutput("abort_rst_rd", bus.rd_data[31:0], 32'h0);
    checkOutput("abort_rst_clr_busy", {31'h0, bus.clr_busy}, 32'h0);
    checkOutput("abort_rst_dbg", bus.dbg_data, 32'h0);
    tick();
    resetn = 1'b1;
    readPair(5'd20, 5'd9);
    checkOutput("abort_r20", bus.rd_data[31:0], 32'h0);
    checkOutput("abort_r9", bus.rd_data[63:32], 32'h0);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.clr_done || bus.clr_busy) cyc++;
      tick();
    end
    checkOutput("abort_no_done", cyc, 32'd0);
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    idle();
    checkOutput("dbg_99", bus.dbg_data, 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
